ex_oitf: RTL
============

Name: ex_oitf

Overview:
- Outstanding Instruction Track FIFO, sitting beside and directly downstream of the dispatch stage.
- Allocates one entry per long-pipe instruction dispatched (AGU/load-store class) and hands the entry index back as the instruction's ITAG.
- Retires entries in order when the long pipe writes back.
- Compares the dispatching instruction's source and destination registers against all live entries, giving dispatch its RAW/WAW hazard flags plus the ready and empty status.

Parameters:
- DEPTH, 2, number of entries; power of two, >=1.
- PTR_W, max(1,clog2(DEPTH)), entry index width; equals E203_ITAG_WIDTH.
- RFIDX_W, 5, register index width.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high, clears all state.
- dis_ena  in  1  allocate request (dispatch handshake fired and instruction is long-pipe).
- dis_ready  out  1  a free entry exists.
- dis_ptr  out  PTR_W  index of the entry the next allocation takes (ITAG).
- disp_i_rs1en  in  1  source 1 is read.
- disp_i_rs2en  in  1  source 2 is read.
- disp_i_rs3en  in  1  source 3 is read (tied 0 in this core).
- disp_i_rdwen  in  1  destination is written.
- disp_i_rs1idx  in  RFIDX_W  source 1 register index.
- disp_i_rs2idx  in  RFIDX_W  source 2 register index.
- disp_i_rs3idx  in  RFIDX_W  source 3 register index.
- disp_i_rdidx  in  RFIDX_W  destination register index.
- disp_i_pc  in  PC_W  dispatching instruction PC.
- ret_ena  in  1  retire the oldest entry (long-pipe writeback done).
- ret_ptr  out  PTR_W  index of the oldest entry.
- ret_rdwen  out  1  oldest entry's rdwen.
- ret_rdidx  out  RFIDX_W  oldest entry's rdidx.
- ret_pc  out  PC_W  oldest entry's PC.
- oitfrd_match_disprs1  out  1  a live entry writes disp_i_rs1idx.
- oitfrd_match_disprs2  out  1  a live entry writes disp_i_rs2idx.
- oitfrd_match_disprs3  out  1  a live entry writes disp_i_rs3idx.
- oitfrd_match_disprd  out  1  a live entry writes disp_i_rdidx.
- oitf_empty  out  1  no live entries.

Behaviour:
- State:
  - alc_ptr and ret_ptr_r, each PTR_W bits with its own wrap flag.
  - Per-entry: vld, rdwen, rdidx, pc.
- Reset (synchronous, rst=1 at clk edge):
  - Pointers, flags and all vld bits go to 0; entry payloads go to 0.
  - Outputs after reset: oitf_empty=1, dis_ready=1, dis_ptr=0, ret_ptr=0, all matches 0, ret_* = 0.
  - rst overrides a simultaneous dis_ena or ret_ena; reset mid-operation discards all outstanding entries.
- Status:
  - empty = (alc_ptr==ret_ptr) & (flags equal).
  - full = (alc_ptr==ret_ptr) & (flags differ).
  - dis_ready = ~full, combinational from registered state only; a same-cycle retire does not free a slot for a same-cycle allocation.
- Allocate: dis_ena & dis_ready.
  - Entry[alc_ptr] gets vld=1 and the disp_i_rdwen/rdidx/pc payload.
  - alc_ptr increments; on passing DEPTH-1 it wraps to 0 and toggles its flag.
  - dis_ena while full is ignored with no state change; the bench flags it as an error.
- Retire: ret_ena & ~empty.
  - Entry[ret_ptr] vld clears; ret_ptr increments with the same wrap rule.
  - ret_ena while empty is ignored.
- Allocate and retire in the same cycle (not full) both take effect. The count is unchanged and oitf_empty/dis_ready keep their values.
- DEPTH=1:
  - Pointer value is constant 0; only the flag toggles.
  - full/empty derive solely from flag equality.
- Hazard matches (combinational, zero latency, registered entries only):
  - rsN match = rsNen & OR over entries of (vld & rdwen & rdidx==rsNidx).
  - rd match = disp_i_rdwen & the same OR with rdidx==disp_i_rdidx.
  - The entry being allocated this cycle is not visible until the next cycle.
  - The entry retiring this cycle still matches (conservative); it clears next cycle.
  - Register index 0 is not special-cased.
- ret_rdwen, ret_rdidx and ret_pc show entry[ret_ptr] continuously; they are valid only when ~oitf_empty.
- Latency: allocate-to-visible is 1 cycle; retire-to-free is 1 cycle.

Decomposition:
- gen_defines: E203_OITF_DEPTH, E203_ITAG_WIDTH (=PTR_W), E203_RFIDX_WIDTH, E203_PC_SIZE.
- Sub-module oitf_ptr: PTR_W counter with wrap flag, ports inc/ptr/flag. It is instantiated twice, for the allocate and retire pointers.

Test Plan:
- Reset, then idle → oitf_empty=1, dis_ready=1, dis_ptr=0, all matches 0.
- DEPTH=2: allocate rd=5 then rd=7 on two cycles → dis_ready=0 in cycle 3. Issue dis_ena while full → no change. Probe rs1idx=7 with rs1en=1 → match_disprs1=1.
- Allocate rd=5 at ptr 0, then rs2idx=5 with rs2en=0 → match_disprs2=0. Set rs2en=1 → 1. Set rdidx=5 with rdwen=1 → match_disprd=1.
- Full FIFO, ret_ena and dis_ena in the same cycle → only the retire happens. Next cycle dis_ready=1, ret_ptr=1, dis_ptr=0 (wrapped).
- Non-full with one entry: simultaneous allocate (rd=3) and retire (rd=5) → next cycle oitf_empty=0, rd=5 no longer matches, rd=3 matches.
- Allocate 3 entries with 3 retires, crossing the wrap → pointers and flags return consistent and oitf_empty=1. Assert rst mid-stream with 1 entry live → next cycle oitf_empty=1 and matches 0.

Source files
------------

// File: rtl/ex_oitf_pkg.sv
//------------------------------------------------------------------------------
// Module   : ex_oitf_pkg
// Brief    : Shared widths and sizing helper for the outstanding-instruction FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ex_oitf_pkg;

  // Entry-index width, never narrower than one bit so DEPTH=1 still has a port.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int E203_OITF_DEPTH  = 2;
  localparam int E203_ITAG_WIDTH  = ptr_width(E203_OITF_DEPTH);
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_PC_SIZE     = 32;

endpackage

`default_nettype wire

// File: rtl/ex_oitf_ptr.sv
//------------------------------------------------------------------------------
// Module   : ex_oitf_ptr
// Brief    : Wrapping entry pointer with a lap flag; the flag disambiguates full/empty.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_oitf_ptr #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr,
  output logic             flag
);

  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] r_ptr;
  logic             r_flag;

  // With DEPTH=1 the pointer is always at C_LAST, so only the flag moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_flag <= 1'b0;
    end else if (inc) begin
      if (r_ptr == C_LAST) begin
        r_ptr  <= '0;
        r_flag <= ~r_flag;
      end else begin
        r_ptr  <= r_ptr + 1'b1;
      end
    end
  end

  assign ptr  = r_ptr;
  assign flag = r_flag;

endmodule

`default_nettype wire

// File: rtl/ex_oitf.sv
//------------------------------------------------------------------------------
// Module   : ex_oitf
// Brief    : Outstanding Instruction Track FIFO: ITAG allocation, in-order retire, RAW/WAW flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_oitf
  import ex_oitf_pkg::*;
#(
  parameter int DEPTH   = E203_OITF_DEPTH,
  parameter int PTR_W   = ptr_width(DEPTH),
  parameter int RFIDX_W = E203_RFIDX_WIDTH,
  parameter int PC_W    = E203_PC_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dis_ena,
  output logic               dis_ready,
  output logic [PTR_W-1:0]   dis_ptr,
  input  logic               disp_i_rs1en,
  input  logic               disp_i_rs2en,
  input  logic               disp_i_rs3en,
  input  logic               disp_i_rdwen,
  input  logic [RFIDX_W-1:0] disp_i_rs1idx,
  input  logic [RFIDX_W-1:0] disp_i_rs2idx,
  input  logic [RFIDX_W-1:0] disp_i_rs3idx,
  input  logic [RFIDX_W-1:0] disp_i_rdidx,
  input  logic [PC_W-1:0]    disp_i_pc,
  input  logic               ret_ena,
  output logic [PTR_W-1:0]   ret_ptr,
  output logic               ret_rdwen,
  output logic [RFIDX_W-1:0] ret_rdidx,
  output logic [PC_W-1:0]    ret_pc,
  output logic               oitfrd_match_disprs1,
  output logic               oitfrd_match_disprs2,
  output logic               oitfrd_match_disprs3,
  output logic               oitfrd_match_disprd,
  output logic               oitf_empty
);

  logic [PTR_W-1:0] w_alc_ptr;
  logic [PTR_W-1:0] w_ret_ptr;
  logic             w_alc_flag;
  logic             w_ret_flag;
  logic             w_ptr_eq;
  logic             w_empty;
  logic             w_full;
  logic             w_alc_ena;
  logic             w_ret_ena;

  logic               r_vld   [DEPTH];
  logic               r_rdwen [DEPTH];
  logic [RFIDX_W-1:0] r_rdidx [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];

  ex_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_alc_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_alc_ena),
    .ptr  (w_alc_ptr),
    .flag (w_alc_flag)
  );

  ex_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ret_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_ret_ena),
    .ptr  (w_ret_ptr),
    .flag (w_ret_flag)
  );

  // Status comes from registered pointers only; a same-cycle retire frees nothing yet.
  assign w_ptr_eq  = (w_alc_ptr == w_ret_ptr);
  assign w_empty   = w_ptr_eq & (w_alc_flag == w_ret_flag);
  assign w_full    = w_ptr_eq & (w_alc_flag != w_ret_flag);
  assign w_alc_ena = dis_ena & ~w_full;
  assign w_ret_ena = ret_ena & ~w_empty;

  // Allocate and retire never target the same slot: that would need full and empty at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]   <= 1'b0;
        r_rdwen[i] <= 1'b0;
        r_rdidx[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alc_ena && (w_alc_ptr == PTR_W'(i))) begin
          r_vld[i]   <= 1'b1;
          r_rdwen[i] <= disp_i_rdwen;
          r_rdidx[i] <= disp_i_rdidx;
          r_pc[i]    <= disp_i_pc;
        end else if (w_ret_ena && (w_ret_ptr == PTR_W'(i))) begin
          r_vld[i]   <= 1'b0;
        end
      end
    end
  end

  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_hit_rs3;
  logic w_hit_rd;

  always_comb begin
    w_hit_rs1 = 1'b0;
    w_hit_rs2 = 1'b0;
    w_hit_rs3 = 1'b0;
    w_hit_rd  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && r_rdwen[i]) begin
        if (r_rdidx[i] == disp_i_rs1idx) w_hit_rs1 = 1'b1;
        if (r_rdidx[i] == disp_i_rs2idx) w_hit_rs2 = 1'b1;
        if (r_rdidx[i] == disp_i_rs3idx) w_hit_rs3 = 1'b1;
        if (r_rdidx[i] == disp_i_rdidx)  w_hit_rd  = 1'b1;
      end
    end
  end

  assign oitfrd_match_disprs1 = disp_i_rs1en & w_hit_rs1;
  assign oitfrd_match_disprs2 = disp_i_rs2en & w_hit_rs2;
  assign oitfrd_match_disprs3 = disp_i_rs3en & w_hit_rs3;
  assign oitfrd_match_disprd  = disp_i_rdwen & w_hit_rd;

  assign dis_ready  = ~w_full;
  assign dis_ptr    = w_alc_ptr;
  assign ret_ptr    = w_ret_ptr;
  assign oitf_empty = w_empty;
  assign ret_rdwen  = r_rdwen[w_ret_ptr];
  assign ret_rdidx  = r_rdidx[w_ret_ptr];
  assign ret_pc     = r_pc[w_ret_ptr];

endmodule

`default_nettype wire
